exec_writeback: RTL and testbench

//  Stage directly downstream of the execution stage; consumes its int/fixed/vector results and N/V/Z flags.

---
 rtl/wb_pkg.sv | 54 +++++
 rtl/vec_beat_serializer.sv | 100 ++++++++++
 rtl/exec_writeback.sv | 177 +++++++++++++++++
 tb/tb_exec_writeback.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and opcode decode for the execution writeback stage.
package wb_pkg;

   typedef enum logic [1:0] {
      CLS_INT   = 2'b00,
      CLS_FIXED = 2'b01,
      CLS_VEC   = 2'b10,
      CLS_NONE  = 2'b11
   } op_class_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_SCAL = 2'b01,
      S_VEC  = 2'b10
   } wb_state_e;

   localparam logic [4:0] OP_INT_0   = 5'b00000;
   localparam logic [4:0] OP_INT_1   = 5'b00001;
   localparam logic [4:0] OP_INT_2   = 5'b00010;
   localparam logic [4:0] OP_FIXED_0 = 5'b01000;
   localparam logic [4:0] OP_FIXED_1 = 5'b01001;
   localparam logic [4:0] OP_FIXED_2 = 5'b01010;
   localparam logic [4:0] OP_VEC_0   = 5'b10000;
   localparam logic [4:0] OP_VEC_1   = 5'b10001;
   localparam logic [4:0] OP_VEC_2   = 5'b10010;

   function automatic logic is_valid_op(input logic [4:0] op);
      logic ok;
      case (op)
         OP_INT_0, OP_INT_1, OP_INT_2,
         OP_FIXED_0, OP_FIXED_1, OP_FIXED_2,
         OP_VEC_0, OP_VEC_1, OP_VEC_2: ok = 1'b1;
         default:                      ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Invalid opcodes collapse to CLS_NONE so callers need only one decode.
   function automatic op_class_e op_class(input logic [4:0] op);
      op_class_e cls;
      if (!is_valid_op(op)) begin
         cls = CLS_NONE;
      end else begin
         case (op[4:3])
            2'b00:   cls = CLS_INT;
            2'b01:   cls = CLS_FIXED;
            2'b10:   cls = CLS_VEC;
            default: cls = CLS_NONE;
         endcase
      end
      return cls;
   endfunction

endpackage

// File: rtl/vec_beat_serializer.sv
// Captures one vector result and replays it to the vector register file,
// LANES_PER_BEAT lanes per cycle; a load on the last beat restarts with no gap.
module vec_beat_serializer
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int VECTOR_LENGTH  = 16,
   parameter int LANES_PER_BEAT = 4,
   parameter int REG_ADDR_W     = 4,
   parameter int LANE_W         = $clog2(VECTOR_LENGTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] data_i [VECTOR_LENGTH],
   input  logic [REG_ADDR_W-1:0] addr_i,
   output logic                  last_beat_o,
   output logic                  vreg_we_o,
   output logic [REG_ADDR_W-1:0] vreg_waddr_o,
   output logic [LANE_W-1:0]     vreg_lane_base_o,
   output logic [DATA_WIDTH-1:0] vreg_wdata_o [LANES_PER_BEAT]
);

   localparam int NUM_BEATS = VECTOR_LENGTH / LANES_PER_BEAT;
   localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

   if ((VECTOR_LENGTH % LANES_PER_BEAT) != 0) begin : g_bad_cfg
      $error("VECTOR_LENGTH must be a multiple of LANES_PER_BEAT");
   end

   logic [DATA_WIDTH-1:0] buf_q [NUM_BEATS][LANES_PER_BEAT];
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic                  active_q, active_d;
   logic [REG_ADDR_W-1:0] addr_q, addr_d;
   logic                  last_s;

   assign last_s = active_q && (beat_q == BEAT_W'(NUM_BEATS - 1));

   // Beat sequencing: load wins over retirement of the last beat.
   always_comb begin
      active_d = active_q;
      beat_d   = beat_q;
      addr_d   = addr_q;
      if (load_i) begin
         active_d = 1'b1;
         beat_d   = '0;
         addr_d   = addr_i;
      end else if (last_s) begin
         active_d = 1'b0;
         beat_d   = '0;
      end else if (active_q) begin
         beat_d   = beat_q + 1'b1;
      end else begin
         active_d = 1'b0;
      end
   end

   // Control registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         beat_q   <= '0;
         addr_q   <= '0;
      end else begin
         active_q <= active_d;
         beat_q   <= beat_d;
         addr_q   <= addr_d;
      end
   end

   // Vector buffer, organised by beat so the read side needs no lane arithmetic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NUM_BEATS; b++) begin
            for (int k = 0; k < LANES_PER_BEAT; k++) begin
               buf_q[b][k] <= '0;
            end
         end
      end else if (load_i) begin
         for (int b = 0; b < NUM_BEATS; b++) begin
            for (int k = 0; k < LANES_PER_BEAT; k++) begin
               buf_q[b][k] <= data_i[b*LANES_PER_BEAT + k];
            end
         end
      end
   end

   assign last_beat_o      = last_s;
   assign vreg_we_o        = active_q;
   assign vreg_waddr_o     = addr_q;
   assign vreg_lane_base_o = LANE_W'(int'(beat_q) * LANES_PER_BEAT);

   // Present the current beat's slice.
   always_comb begin
      for (int k = 0; k < LANES_PER_BEAT; k++) begin
         vreg_wdata_o[k] = buf_q[beat_q][k];
      end
   end

endmodule

// File: rtl/exec_writeback.sv
// Writeback stage: scalar RF write, vector beat serialisation, flag registers.
// Optional same-cycle forwarding outputs are enabled by defining WB_BYPASS_EN.
module exec_writeback
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int VECTOR_LENGTH  = 16,
   parameter int LANES_PER_BEAT = 4,
   parameter int REG_ADDR_W     = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [4:0]                          opcode,
   input  logic [REG_ADDR_W-1:0]               rd,
   input  logic signed [DATA_WIDTH-1:0]        out_int,
   input  logic signed [DATA_WIDTH-1:0]        out_fixed,
   input  logic [DATA_WIDTH-1:0]               out_vector [VECTOR_LENGTH],
   input  logic                                n_int,
   input  logic                                v_int,
   input  logic                                z_int,
   input  logic                                n_fixed,
   input  logic                                v_fixed,
   input  logic                                z_fixed,
   input  logic [VECTOR_LENGTH-1:0]            n_vector,
   input  logic [VECTOR_LENGTH-1:0]            v_vector,
   input  logic [VECTOR_LENGTH-1:0]            z_vector,
   output logic                                sreg_we,
   output logic [REG_ADDR_W-1:0]               sreg_waddr,
   output logic [DATA_WIDTH-1:0]               sreg_wdata,
   output logic                                vreg_we,
   output logic [REG_ADDR_W-1:0]               vreg_waddr,
   output logic [$clog2(VECTOR_LENGTH)-1:0]    vreg_lane_base,
   output logic [DATA_WIDTH-1:0]               vreg_wdata [LANES_PER_BEAT],
   output logic [2:0]                          flags_nzv,
   output logic [VECTOR_LENGTH-1:0]            vflags_n,
   output logic [VECTOR_LENGTH-1:0]            vflags_v,
   output logic [VECTOR_LENGTH-1:0]            vflags_z,
   output logic                                busy
`ifdef WB_BYPASS_EN
   ,
   output logic                                fwd_valid,
   output logic [REG_ADDR_W-1:0]               fwd_rd,
   output logic [DATA_WIDTH-1:0]               fwd_data
`endif
);

   wb_state_e              state_q, state_d;
   op_class_e              cls_s;
   logic                   xfer_s;
   logic                   scal_s;
   logic                   vec_load_s;
   logic                   last_beat_s;
   logic [DATA_WIDTH-1:0]  scal_data_s;

   logic                   sreg_we_q, sreg_we_d;
   logic [REG_ADDR_W-1:0]  sreg_waddr_q, sreg_waddr_d;
   logic [DATA_WIDTH-1:0]  sreg_wdata_q, sreg_wdata_d;
   logic [2:0]             flags_nzv_q, flags_nzv_d;
   logic [VECTOR_LENGTH-1:0] vflags_n_q, vflags_n_d;
   logic [VECTOR_LENGTH-1:0] vflags_v_q, vflags_v_d;
   logic [VECTOR_LENGTH-1:0] vflags_z_q, vflags_z_d;

   assign cls_s       = op_class(opcode);
   assign scal_s      = (cls_s == CLS_INT) || (cls_s == CLS_FIXED);
   assign scal_data_s = (cls_s == CLS_FIXED) ? out_fixed : out_int;
   // Held low during reset so nothing is accepted before the stage is live.
   assign in_ready    = !rst && ((state_q != S_VEC) || last_beat_s);
   assign xfer_s      = in_valid && in_ready;
   assign vec_load_s  = xfer_s && (cls_s == CLS_VEC);

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      if (xfer_s) begin
         case (cls_s)
            CLS_INT, CLS_FIXED: state_d = S_SCAL;
            CLS_VEC:            state_d = S_VEC;
            default:            state_d = S_IDLE;
         endcase
      end else if ((state_q == S_VEC) && !last_beat_s) begin
         state_d = S_VEC;
      end else begin
         state_d = S_IDLE;
      end
   end

   // Scalar write port and flag next-state.
   always_comb begin
      sreg_we_d    = xfer_s && scal_s;
      sreg_waddr_d = sreg_waddr_q;
      sreg_wdata_d = sreg_wdata_q;
      flags_nzv_d  = flags_nzv_q;
      vflags_n_d   = vflags_n_q;
      vflags_v_d   = vflags_v_q;
      vflags_z_d   = vflags_z_q;
      if (sreg_we_d) begin
         sreg_waddr_d = rd;
         sreg_wdata_d = scal_data_s;
      end else begin
         sreg_waddr_d = sreg_waddr_q;
      end
      if (xfer_s) begin
         case (cls_s)
            CLS_INT:   flags_nzv_d = {n_int, v_int, z_int};
            CLS_FIXED: flags_nzv_d = {n_fixed, v_fixed, z_fixed};
            CLS_VEC: begin
               vflags_n_d = n_vector;
               vflags_v_d = v_vector;
               vflags_z_d = z_vector;
            end
            default:   flags_nzv_d = flags_nzv_q;
         endcase
      end else begin
         flags_nzv_d = flags_nzv_q;
      end
   end

   // State, scalar write port and flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         sreg_we_q    <= 1'b0;
         sreg_waddr_q <= '0;
         sreg_wdata_q <= '0;
         flags_nzv_q  <= 3'b000;
         vflags_n_q   <= '0;
         vflags_v_q   <= '0;
         vflags_z_q   <= '0;
      end else begin
         state_q      <= state_d;
         sreg_we_q    <= sreg_we_d;
         sreg_waddr_q <= sreg_waddr_d;
         sreg_wdata_q <= sreg_wdata_d;
         flags_nzv_q  <= flags_nzv_d;
         vflags_n_q   <= vflags_n_d;
         vflags_v_q   <= vflags_v_d;
         vflags_z_q   <= vflags_z_d;
      end
   end

   vec_beat_serializer #(
      .DATA_WIDTH     (DATA_WIDTH),
      .VECTOR_LENGTH  (VECTOR_LENGTH),
      .LANES_PER_BEAT (LANES_PER_BEAT),
      .REG_ADDR_W     (REG_ADDR_W),
      .LANE_W         ($clog2(VECTOR_LENGTH))
   ) u_ser (
      .clk              (clk),
      .rst              (rst),
      .load_i           (vec_load_s),
      .data_i           (out_vector),
      .addr_i           (rd),
      .last_beat_o      (last_beat_s),
      .vreg_we_o        (vreg_we),
      .vreg_waddr_o     (vreg_waddr),
      .vreg_lane_base_o (vreg_lane_base),
      .vreg_wdata_o     (vreg_wdata)
   );

   assign sreg_we    = sreg_we_q;
   assign sreg_waddr = sreg_waddr_q;
   assign sreg_wdata = sreg_wdata_q;
   assign flags_nzv  = flags_nzv_q;
   assign vflags_n   = vflags_n_q;
   assign vflags_v   = vflags_v_q;
   assign vflags_z   = vflags_z_q;
   assign busy       = (state_q != S_IDLE);

`ifdef WB_BYPASS_EN
   assign fwd_valid = xfer_s && scal_s;
   assign fwd_rd    = rd;
   assign fwd_data  = scal_data_s;
`endif

endmodule

// File: tb/tb_exec_writeback.sv
// Scoreboard bench for exec_writeback: stimulus pushes expected RF writes,
// a negedge monitor pops and compares whenever a write enable is seen.
module tb_exec_writeback;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  opcode;
   logic [3:0]  rd;
   logic signed [15:0] out_int;
   logic signed [15:0] out_fixed;
   logic [15:0] vec [16];
   logic        n_int, v_int, z_int, n_fixed, v_fixed, z_fixed;
   logic [15:0] n_vector, v_vector, z_vector;
   logic        sreg_we;
   logic [3:0]  sreg_waddr;
   logic [15:0] sreg_wdata;
   logic        vreg_we;
   logic [3:0]  vreg_waddr;
   logic [3:0]  vreg_lane_base;
   logic [15:0] vreg_wdata [4];
   logic [2:0]  flags_nzv;
   logic [15:0] vflags_n, vflags_v, vflags_z;
   logic        busy;
`ifdef WB_BYPASS_EN
   logic        fwd_valid;
   logic [3:0]  fwd_rd;
   logic [15:0] fwd_data;
`endif

   exec_writeback dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .rd(rd), .out_int(out_int), .out_fixed(out_fixed),
      .out_vector(vec),
      .n_int(n_int), .v_int(v_int), .z_int(z_int),
      .n_fixed(n_fixed), .v_fixed(v_fixed), .z_fixed(z_fixed),
      .n_vector(n_vector), .v_vector(v_vector), .z_vector(z_vector),
      .sreg_we(sreg_we), .sreg_waddr(sreg_waddr), .sreg_wdata(sreg_wdata),
      .vreg_we(vreg_we), .vreg_waddr(vreg_waddr), .vreg_lane_base(vreg_lane_base),
      .vreg_wdata(vreg_wdata), .flags_nzv(flags_nzv),
      .vflags_n(vflags_n), .vflags_v(vflags_v), .vflags_z(vflags_z),
      .busy(busy)
`ifdef WB_BYPASS_EN
      , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
   );

   int checks = 0;
   int errors = 0;
   logic [19:0] sq [$];   // {addr, data}
   logic [71:0] vq [$];   // {addr, lane_base, lane3..lane0}

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vec(input logic [15:0] base);
      for (int i = 0; i < 16; i++) vec[i] = base + 16'(i);
   endtask

   task automatic push_beat(input logic [3:0] addr, input logic [15:0] base, input int b);
      logic [63:0] d;
      for (int k = 0; k < 4; k++) d[k*16 +: 16] = base + 16'(b*4 + k);
      vq.push_back({addr, 4'(b*4), d});
   endtask

   task automatic push_vec(input logic [3:0] addr, input logic [15:0] base);
      for (int b = 0; b < 4; b++) push_beat(addr, base, b);
   endtask

   // Monitor: pops one expectation per observed write.
   always @(negedge clk) begin
      logic [19:0] se;
      logic [71:0] ve;
      if (!rst) begin
         chk("we_exclusive", {1'b0, sreg_we & vreg_we}, 72'd0);
         if (sreg_we) begin
            if (sq.size() == 0) begin
               checks++; errors++;
               $display("FAIL sreg_unexpected actual=%h_%h expected=no_write", sreg_waddr, sreg_wdata);
            end else begin
               se = sq.pop_front();
               chk("sreg_write", {sreg_waddr, sreg_wdata}, se);
            end
         end
         if (vreg_we) begin
            if (vq.size() == 0) begin
               checks++; errors++;
               $display("FAIL vreg_unexpected actual=%h_%h expected=no_write", vreg_waddr, vreg_lane_base);
            end else begin
               ve = vq.pop_front();
               chk("vreg_beat", {vreg_waddr, vreg_lane_base, vreg_wdata[3], vreg_wdata[2],
                                 vreg_wdata[1], vreg_wdata[0]}, ve);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "timeout");
   end

   initial begin
      int wait_c, beats, cyc;
      rst = 1'b1; in_valid = 1'b0; opcode = 5'd0; rd = 4'd0;
      out_int = 16'sd0; out_fixed = 16'sd0;
      n_int = 1'b0; v_int = 1'b0; z_int = 1'b0;
      n_fixed = 1'b0; v_fixed = 1'b0; z_fixed = 1'b0;
      n_vector = 16'h0; v_vector = 16'h0; z_vector = 16'h0;
      set_vec(16'h0000);

      @(negedge clk);
      chk("rst_sreg_we", sreg_we, 1'b0);
      chk("rst_vreg_we", vreg_we, 1'b0);
      chk("rst_flags", flags_nzv, 3'b000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", in_ready, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      chk("ready_after_rst", in_ready, 1'b1);

      // T1: int op
      in_valid = 1'b1; opcode = 5'b00000; rd = 4'd3;
      out_int = 16'sh0042; out_fixed = 16'sh1111;
      sq.push_back({4'd3, 16'h0042});
      tick();
      in_valid = 1'b0;
      chk("t1_flags", flags_nzv, 3'b000);
      chk("t1_busy", busy, 1'b1);
      tick();
      chk("t1_idle", busy, 1'b0);

      // T2: fixed then int, back to back
      in_valid = 1'b1; opcode = 5'b01001; rd = 4'd7;
      out_fixed = 16'sh8001; out_int = 16'sh1234;
      n_fixed = 1'b1; v_fixed = 1'b1; z_fixed = 1'b0;
      n_int = 1'b0; v_int = 1'b0; z_int = 1'b1;
      sq.push_back({4'd7, 16'h8001});
      tick();
      chk("t2_ready", in_ready, 1'b1);
      chk("t2_flags_fixed", flags_nzv, 3'b110);
      opcode = 5'b00010; rd = 4'd2; out_int = 16'sh0000; out_fixed = 16'sh5555;
      sq.push_back({4'd2, 16'h0000});
      tick();
      in_valid = 1'b0;
      chk("t2_flags_int", flags_nzv, 3'b001);
      chk("t2_ready2", in_ready, 1'b1);
      tick();

      // T3: single vector
      set_vec(16'h0000);
      n_vector = 16'hA5A5; v_vector = 16'h0F0F; z_vector = 16'h0001;
      n_int = 1'b1;
      in_valid = 1'b1; opcode = 5'b10000; rd = 4'd5;
      push_vec(4'd5, 16'h0000);
      tick();
      in_valid = 1'b0;
      chk("t3_vflags_n", vflags_n, 16'hA5A5);
      chk("t3_vflags_v", vflags_v, 16'h0F0F);
      chk("t3_vflags_z", vflags_z, 16'h0001);
      chk("t3_flags_held", flags_nzv, 3'b001);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("t3_ready_c%0d", c), in_ready, (c == 3));
         tick();
      end
      chk("t3_done", busy, 1'b0);

      // T4: second vector pending, chained on the last beat
      set_vec(16'h0100);
      in_valid = 1'b1; opcode = 5'b10001; rd = 4'd6;
      push_vec(4'd6, 16'h0100);
      push_vec(4'd9, 16'h0200);
      tick();
      set_vec(16'h0200); opcode = 5'b10010; rd = 4'd9;
      wait_c = 0; beats = 0;
      while (!in_ready && wait_c < 10) begin
         beats += int'(vreg_we);
         tick();
         wait_c++;
      end
      chk("t4_wait", 72'(wait_c), 72'd3);
      beats += int'(vreg_we);
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (busy && cyc < 10) begin
         beats += int'(vreg_we);
         cyc++;
         tick();
      end
      chk("t4_beats", 72'(beats), 72'd8);
      chk("t4_tail", 72'(cyc), 72'd4);

      // T5: reset mid-vector
      set_vec(16'h0300);
      in_valid = 1'b1; opcode = 5'b10000; rd = 4'd4;
      push_beat(4'd4, 16'h0300, 0);
      push_beat(4'd4, 16'h0300, 1);
      tick();
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("t5_sreg_we", sreg_we, 1'b0);
      chk("t5_vreg_we", vreg_we, 1'b0);
      chk("t5_vreg_waddr", vreg_waddr, 4'd0);
      chk("t5_lane_base", vreg_lane_base, 4'd0);
      chk("t5_wdata0", vreg_wdata[0], 16'h0000);
      chk("t5_flags", flags_nzv, 3'b000);
      chk("t5_vflags_n", vflags_n, 16'h0000);
      chk("t5_busy", busy, 1'b0);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("t5_no_beat_c%0d", c), vreg_we, 1'b0);
         tick();
      end
      chk("t5_ready", in_ready, 1'b1);

      // rd = 0 still writes; then flags 110 become the reference
      in_valid = 1'b1; opcode = 5'b00001; rd = 4'd0; out_int = -16'sd1;
      n_int = 1'b1; v_int = 1'b1; z_int = 1'b0;
      sq.push_back({4'd0, 16'hFFFF});
      tick();
      in_valid = 1'b0;
      chk("t5_rd0_flags", flags_nzv, 3'b110);

      // Invalid opcodes: no write, flags unchanged
      in_valid = 1'b1; opcode = 5'b11111; rd = 4'd8;
      n_int = 1'b0; v_int = 1'b0; z_int = 1'b1;
      n_fixed = 1'b0; v_fixed = 1'b0; z_fixed = 1'b1;
      n_vector = 16'hFFFF;
      tick();
      in_valid = 1'b0;
      chk("t5_inv_flags", flags_nzv, 3'b110);
      chk("t5_inv_vflags", vflags_n, 16'h0000);
      chk("t5_inv_busy", busy, 1'b0);
      in_valid = 1'b1; opcode = 5'b00011;
      tick();
      in_valid = 1'b0;
      chk("t5_inv2_flags", flags_nzv, 3'b110);
      chk("t5_inv2_busy", busy, 1'b0);
      tick();

`ifdef WB_BYPASS_EN
      // T6: same-cycle forwarding
      in_valid = 1'b1; opcode = 5'b00000; rd = 4'd1; out_int = 16'sh7FFF;
      #1;
      chk("t6_fwd_valid", fwd_valid, 1'b1);
      chk("t6_fwd_data", fwd_data, 16'h7FFF);
      chk("t6_fwd_rd", fwd_rd, 4'd1);
      sq.push_back({4'd1, 16'h7FFF});
      tick();
      in_valid = 1'b0;
      #1;
      chk("t6_fwd_idle", fwd_valid, 1'b0);
      tick();
`endif

      repeat (3) tick();
      chk("sq_drained", 72'(sq.size()), 72'd0);
      chk("vq_drained", 72'(vq.size()), 72'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
